// File: rtl/alu_pkg.sv
// alu_pkg: constants and types shared by the ALU and the stages around it.
//   - ALUControl operation codes (ALU_AND .. ALU_SRA)
//   - alu_res_t: one captured ALU result (result, zero, neg, ctrl, rd)
//   - resbuf_state_t: occupancy of the two-entry result buffer
package alu_pkg;

    localparam int ALU_DATA_W = 32;
    localparam int ALU_RD_W   = 5;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLL = 4'b1000;
    localparam logic [3:0] ALU_SRL = 4'b1001;
    localparam logic [3:0] ALU_SRA = 4'b1010;

    typedef struct packed {
        logic [ALU_DATA_W-1:0] result;
        logic                  zero;
        logic                  neg;
        logic [3:0]            ctrl;
        logic [ALU_RD_W-1:0]   rd;
    } alu_res_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } resbuf_state_t;

endpackage

// File: rtl/alu_resbuf_stats.sv
// alu_resbuf_stats: pair of saturating event counters for the result buffer.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset (clears both counters)
//   inc_total   count one accepted entry
//   inc_zero    count one accepted entry whose Zero flag was set
//   total, zero counter values; each sticks at all-ones once reached
module alu_resbuf_stats #(
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc_total,
    input  logic              inc_zero,
    output logic [STAT_W-1:0] total,
    output logic [STAT_W-1:0] zero
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            total <= '0;
            zero  <= '0;
        end else begin
            if (inc_total && (total != '1)) total <= total + 1'b1;
            if (inc_zero  && (zero  != '1)) zero  <= zero + 1'b1;
        end
    end

endmodule

// File: rtl/alu_result_buffer.sv
// alu_result_buffer: two-entry skid buffer between the ALU and memory/writeback.
// Holds each ALU result with its Zero flag, sign bit, ALUControl code and
// destination register until downstream accepts it. Full throughput with a
// registered in_ready, so out_ready never reaches in_ready combinationally.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   flush                      synchronous drop of all held entries
//   in_valid/in_ready          upstream handshake (in_ready registered)
//   in_result/zero/ctrl/rd     ALU result payload
//   out_valid/out_ready        downstream handshake
//   out_result/zero/neg/ctrl/rd head entry payload
//   stat_total/stat_zero       accept counters
// Build option: ALU_RESBUF_STATS_EN enables the counters; otherwise the
// stat ports read as zero and no counter flops exist.
module alu_result_buffer
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int RD_W   = ALU_RD_W,
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_result,
    input  logic              in_zero,
    input  logic [3:0]        in_ctrl,
    input  logic [RD_W-1:0]   in_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic              out_zero,
    output logic              out_neg,
    output logic [3:0]        out_ctrl,
    output logic [RD_W-1:0]   out_rd,
    output logic [STAT_W-1:0] stat_total,
    output logic [STAT_W-1:0] stat_zero
);

    // Same layout as alu_res_t, sized by this instance's parameters.
    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic              zero;
        logic              neg;
        logic [3:0]        ctrl;
        logic [RD_W-1:0]   rd;
    } entry_t;

    resbuf_state_t state;
    entry_t        head, skid, in_entry;
    logic          accept, drain;

    assign accept = in_valid & in_ready;
    assign drain  = out_valid & out_ready;

    always_comb begin
        in_entry        = '0;
        in_entry.result = in_result;
        in_entry.zero   = in_zero;
        in_entry.neg    = in_result[DATA_W-1];
        in_entry.ctrl   = in_ctrl;
        in_entry.rd     = in_rd;
    end

    // out_valid and in_ready are kept as flops alongside the state so both
    // handshake outputs come straight from registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            head      <= '0;
            skid      <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else if (flush) begin
            // Payload registers keep their last value; only occupancy clears.
            state     <= EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        head      <= in_entry;
                        state     <= ONE;
                        out_valid <= 1'b1;
                    end
                end
                ONE: begin
                    if (accept && drain) begin
                        head <= in_entry;
                    end else if (accept) begin
                        // Downstream stalled: park the new entry behind the head.
                        skid     <= in_entry;
                        state    <= TWO;
                        in_ready <= 1'b0;
                    end else if (drain) begin
                        state     <= EMPTY;
                        out_valid <= 1'b0;
                    end
                end
                TWO: begin
                    if (drain) begin
                        head     <= skid;
                        state    <= ONE;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign out_result = head.result;
    assign out_zero   = head.zero;
    assign out_neg    = head.neg;
    assign out_ctrl   = head.ctrl;
    assign out_rd     = head.rd;

`ifdef ALU_RESBUF_STATS_EN
    alu_resbuf_stats #(
        .STAT_W (STAT_W)
    ) u_stats (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc_total (accept & ~flush),
        .inc_zero  (accept & ~flush & in_zero),
        .total     (stat_total),
        .zero      (stat_zero)
    );
`else
    assign stat_total = '0;
    assign stat_zero  = '0;
`endif

endmodule

// File: tb/tb_alu_result_buffer.sv
module tb_alu_result_buffer;
    import alu_pkg::*;

`ifdef ALU_RESBUF_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
    logic        in_valid = 1'b0, out_ready = 1'b0;
    logic [31:0] in_result = '0;
    logic        in_zero = 1'b0;
    logic [3:0]  in_ctrl = '0;
    logic [4:0]  in_rd = '0;
    logic        in_ready, out_valid, out_zero, out_neg;
    logic [31:0] out_result;
    logic [3:0]  out_ctrl;
    logic [4:0]  out_rd;
    logic [15:0] stat_total, stat_zero;
    logic        in_ready4, out_valid4, out_zero4, out_neg4;
    logic [31:0] out_result4;
    logic [3:0]  out_ctrl4;
    logic [4:0]  out_rd4;
    logic [3:0]  stat_total4, stat_zero4;

    int tests = 0, fails = 0;

    always #5 clk = ~clk;

    alu_result_buffer dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
        .in_zero(in_zero), .in_ctrl(in_ctrl), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_zero(out_zero), .out_neg(out_neg), .out_ctrl(out_ctrl), .out_rd(out_rd),
        .stat_total(stat_total), .stat_zero(stat_zero)
    );

    // Narrow-counter copy on the same stimulus, for saturation.
    alu_result_buffer #(.STAT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready4), .in_result(in_result),
        .in_zero(in_zero), .in_ctrl(in_ctrl), .in_rd(in_rd),
        .out_valid(out_valid4), .out_ready(out_ready), .out_result(out_result4),
        .out_zero(out_zero4), .out_neg(out_neg4), .out_ctrl(out_ctrl4), .out_rd(out_rd4),
        .stat_total(stat_total4), .stat_zero(stat_zero4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] r, input logic z,
                         input logic [3:0] c, input logic [4:0] d);
        in_valid = v; in_result = r; in_zero = z; in_ctrl = c; in_rd = d;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        tests++;
        if ({out_valid, in_ready, out_result, out_zero, out_neg, out_ctrl, out_rd} !== {1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 4'h0, 5'h0}) begin
            fails++;
            $display("FAIL reset_init: valid=%b ready=%b res=%h want valid=0 ready=1 res=0", out_valid, in_ready, out_result);
        end
        rst_n = 1'b1;
        tick();
        out_ready = 1'b0;
        drive(1'b1, 32'hDEAD0001, 1'b1, ALU_XOR, 5'd7);
        tick();
        drive(1'b0, 32'h0, 1'b0, 4'h0, 5'h0);
        tests++;
        if ({out_valid, out_result, out_neg, out_rd} !== {1'b1, 32'hDEAD0001, 1'b1, 5'd7}) begin
            fails++;
            $display("FAIL reset_preload: valid=%b res=%h neg=%b rd=%0d want 1 dead0001 1 7", out_valid, out_result, out_neg, out_rd);
        end
        #3 rst_n = 1'b0;
        #1;
        tests++;
        if ({out_valid, in_ready, out_result, out_zero, out_neg, out_ctrl, out_rd} !== {1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 4'h0, 5'h0}) begin
            fails++;
            $display("FAIL reset_async: valid=%b ready=%b res=%h zero=%b neg=%b ctrl=%h rd=%0d want all 0 ready=1",
                     out_valid, in_ready, out_result, out_zero, out_neg, out_ctrl, out_rd);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_add();
        out_ready = 1'b1;
        drive(1'b1, 32'h30, 1'b0, ALU_ADD, 5'd5);
        tick();
        drive(1'b0, 32'h0, 1'b0, 4'h0, 5'h0);
        tests++;
        if ({out_valid, out_result, out_rd, out_neg, out_ctrl, out_zero} !== {1'b1, 32'h30, 5'd5, 1'b0, ALU_ADD, 1'b0}) begin
            fails++;
            $display("FAIL single_out: valid=%b res=%h rd=%0d neg=%b ctrl=%h want 1 30 5 0 2", out_valid, out_result, out_rd, out_neg, out_ctrl);
        end
        tick();
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL single_drained: valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(1'b1, 32'h20, 1'b0, ALU_SUB, 5'd1);
        tick();
        tests++;
        if ({in_ready, out_valid, out_result} !== {1'b1, 1'b1, 32'h20}) begin
            fails++;
            $display("FAIL bp_first: ready=%b valid=%b res=%h want 1 1 20", in_ready, out_valid, out_result);
        end
        drive(1'b1, 32'h0, 1'b1, ALU_AND, 5'd2);
        tick();
        drive(1'b0, 32'h0, 1'b0, 4'h0, 5'h0);
        tests++;
        if ({in_ready, out_valid, out_result, out_ctrl} !== {1'b0, 1'b1, 32'h20, ALU_SUB}) begin
            fails++;
            $display("FAIL bp_full: ready=%b valid=%b res=%h ctrl=%h want 0 1 20 6", in_ready, out_valid, out_result, out_ctrl);
        end
        tick();
        tests++;
        if ({in_ready, out_result, out_rd} !== {1'b0, 32'h20, 5'd1}) begin
            fails++;
            $display("FAIL bp_hold: ready=%b res=%h rd=%0d want 0 20 1", in_ready, out_result, out_rd);
        end
        out_ready = 1'b1;
        tick();
        tests++;
        if ({in_ready, out_valid, out_result, out_zero, out_ctrl, out_rd} !== {1'b1, 1'b1, 32'h0, 1'b1, ALU_AND, 5'd2}) begin
            fails++;
            $display("FAIL bp_second: ready=%b valid=%b res=%h zero=%b ctrl=%h rd=%0d want 1 1 0 1 0 2",
                     in_ready, out_valid, out_result, out_zero, out_ctrl, out_rd);
        end
        tick();
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL bp_empty: valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 32'(i), 1'b0, ALU_OR, 5'(i));
            tick();
            tests++;
            if ({in_ready, out_valid, out_result, out_rd} !== {1'b1, 1'b1, 32'(i), 5'(i)}) begin
                fails++;
                $display("FAIL stream_%0d: ready=%b valid=%b res=%h rd=%0d want 1 1 %h %0d", i, in_ready, out_valid, out_result, out_rd, i, i);
            end
        end
        drive(1'b0, 32'h0, 1'b0, 4'h0, 5'h0);
        tick();
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL stream_end: valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(1'b1, 32'h1, 1'b0, ALU_XOR, 5'd3);
        tick();
        drive(1'b1, 32'h2, 1'b0, ALU_OR, 5'd4);
        tick();
        drive(1'b1, 32'hFF000000, 1'b0, ALU_SRA, 5'd9);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 4'h0, 5'h0);
        tests++;
        if ({out_valid, in_ready} !== {1'b0, 1'b1}) begin
            fails++;
            $display("FAIL flush_two: valid=%b ready=%b want 0 1", out_valid, in_ready);
        end
        // Flush in ONE while an accept happens: the accepted entry is lost too.
        drive(1'b1, 32'h11, 1'b0, ALU_ADD, 5'd6);
        tick();
        drive(1'b1, 32'hFF000000, 1'b0, ALU_SRA, 5'd9);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 4'h0, 5'h0);
        tick();
        tests++;
        if ({out_valid, in_ready} !== {1'b0, 1'b1}) begin
            fails++;
            $display("FAIL flush_accept_lost: valid=%b ready=%b want 0 1", out_valid, in_ready);
        end
        out_ready = 1'b1;
        drive(1'b1, 32'h55, 1'b0, ALU_SLL, 5'd10);
        tick();
        drive(1'b0, 32'h0, 1'b0, 4'h0, 5'h0);
        tests++;
        if ({out_valid, out_result, out_ctrl, out_rd} !== {1'b1, 32'h55, ALU_SLL, 5'd10}) begin
            fails++;
            $display("FAIL flush_after: valid=%b res=%h ctrl=%h rd=%0d want 1 55 8 10", out_valid, out_result, out_ctrl, out_rd);
        end
        tick();
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL flush_after_drain: valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_stats();
        logic [15:0] exp_t, exp_z;
        logic [3:0]  exp_t4, exp_z4;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        tests++;
        if ({stat_total, stat_zero} !== 32'h0) begin
            fails++;
            $display("FAIL stats_reset: total=%0d zero=%0d want 0 0", stat_total, stat_zero);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, (i == 2 || i == 5 || i == 8) ? 32'h0 : 32'(i + 100),
                  (i == 2 || i == 5 || i == 8), ALU_SUB, 5'(i));
            tick();
        end
        drive(1'b0, 32'h0, 1'b0, 4'h0, 5'h0);
        tick();
        exp_t = STATS ? 16'd10 : 16'd0;
        exp_z = STATS ? 16'd3  : 16'd0;
        tests++;
        if ({stat_total, stat_zero} !== {exp_t, exp_z}) begin
            fails++;
            $display("FAIL stats_count: total=%0d zero=%0d want %0d %0d", stat_total, stat_zero, exp_t, exp_z);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tests++;
        if ({stat_total, stat_zero} !== {exp_t, exp_z}) begin
            fails++;
            $display("FAIL stats_flush_keep: total=%0d zero=%0d want %0d %0d", stat_total, stat_zero, exp_t, exp_z);
        end
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 32'(i + 1), 1'b0, ALU_ADD, 5'(i));
            tick();
        end
        drive(1'b0, 32'h0, 1'b0, 4'h0, 5'h0);
        tick();
        exp_t  = STATS ? 16'd30 : 16'd0;
        exp_t4 = STATS ? 4'd15  : 4'd0;
        exp_z4 = STATS ? 4'd3   : 4'd0;
        tests++;
        if (stat_total !== exp_t) begin
            fails++;
            $display("FAIL stats_total30: total=%0d want %0d", stat_total, exp_t);
        end
        tests++;
        if ({stat_total4, stat_zero4} !== {exp_t4, exp_z4}) begin
            fails++;
            $display("FAIL stats_saturate: total4=%0d zero4=%0d want %0d %0d", stat_total4, stat_zero4, exp_t4, exp_z4);
        end
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_backpressure();
        test_stream();
        test_flush();
        test_stats();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
